// File: rtl/rio_link_vc_credits_if.sv
// Flow-control bundle between the VC credit engine and the link RX/TX control paths.
// The engine uses the slave modport; the surrounding link logic uses master.
interface rio_link_vc_credits_if #(
  parameter int NUM_VC    = 3,
  parameter int VC_WIDTH  = 2,
  parameter int CNT_WIDTH = 8
);
  logic                 i_link_up;
  logic [NUM_VC-1:0]    i_enq;
  logic                 i_ds_credit_valid;
  logic [VC_WIDTH-1:0]  i_ds_credit_vc;
  logic [CNT_WIDTH-1:0] i_ds_credit_cnt;
  logic [NUM_VC-1:0]    i_deq;
  logic                 o_us_credit_valid;
  logic [VC_WIDTH-1:0]  o_us_credit_vc;
  logic [CNT_WIDTH-1:0] o_us_credit_cnt;
  logic                 i_us_credit_accept;
  logic [NUM_VC-1:0]    o_xoff;
  logic                 o_credit_err;

  modport master (
    output i_link_up, i_enq, i_ds_credit_valid, i_ds_credit_vc, i_ds_credit_cnt,
           i_deq, i_us_credit_accept,
    input  o_us_credit_valid, o_us_credit_vc, o_us_credit_cnt, o_xoff, o_credit_err
  );

  modport slave (
    input  i_link_up, i_enq, i_ds_credit_valid, i_ds_credit_vc, i_ds_credit_cnt,
           i_deq, i_us_credit_accept,
    output o_us_credit_valid, o_us_credit_vc, o_us_credit_cnt, o_xoff, o_credit_err
  );
endinterface

// File: rtl/rio_link_vc_credits.sv
// Per-VC credit engine: tracks remote TX credits (xoff) and batches freed RX slots
// into round-robin upstream credit messages, with a refresh timer for partial batches.
module rio_link_vc_credits #(
  parameter int NUM_VC         = 3,
  parameter int VC_WIDTH       = 2,
  parameter int CNT_WIDTH      = 8,
  parameter int REMOTE_DEPTH   = 64,
  parameter int XOFF_THRESH    = 4,
  parameter int CREDIT_BATCH   = 8,
  parameter int REFRESH_CYCLES = 256
) (
  input logic                   clk,
  input logic                   rst,
  rio_link_vc_credits_if.slave  bus
);
  localparam int TMR_WIDTH = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] tx_credit_reg  [NUM_VC];
  logic [CNT_WIDTH-1:0] tx_credit_next [NUM_VC];
  logic [CNT_WIDTH-1:0] pending_reg    [NUM_VC];
  logic [CNT_WIDTH-1:0] pending_next   [NUM_VC];
  logic [NUM_VC-1:0]    flag_reg, flag_next, eligible;
  logic [NUM_VC-1:0]    tx_under, tx_over, pend_sat, acc_hit;
  logic [NUM_VC-1:0]    xoff_reg;
  logic [TMR_WIDTH-1:0] timer_reg;
  logic                 timer_wrap;
  logic [VC_WIDTH-1:0]  vc_reg, vc_next, rr_reg, rr_next, pick_vc;
  logic [VC_WIDTH:0]    rr_sum;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 pick_found, accept_fire, bad_vc, err_reg, err_next;

  assign accept_fire = (state_reg == ST_OFFER) && bus.i_us_credit_accept;
  assign timer_wrap  = (timer_reg == TMR_WIDTH'(REFRESH_CYCLES - 1));
  assign bad_vc      = bus.i_ds_credit_valid &&
                       ({1'b0, bus.i_ds_credit_vc} >= (VC_WIDTH + 1)'(NUM_VC));

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [CNT_WIDTH:0] add_w, sum_w;

    // Credit arithmetic is one bit wider so overflow past REMOTE_DEPTH is visible.
    assign add_w = (bus.i_ds_credit_valid && bus.i_ds_credit_vc == VC_WIDTH'(gi)) ?
                   {1'b0, bus.i_ds_credit_cnt} : '0;
    assign sum_w = {1'b0, tx_credit_reg[gi]} + add_w - (CNT_WIDTH + 1)'(bus.i_enq[gi]);
    assign tx_under[gi] = (tx_credit_reg[gi] == '0) && bus.i_enq[gi] && (add_w == '0);
    assign tx_over[gi]  = !tx_under[gi] && (sum_w > (CNT_WIDTH + 1)'(REMOTE_DEPTH));
    assign tx_credit_next[gi] = tx_under[gi] ? '0 :
                                tx_over[gi]  ? CNT_WIDTH'(REMOTE_DEPTH) :
                                               sum_w[CNT_WIDTH-1:0];

    assign acc_hit[gi]  = accept_fire && (vc_reg == VC_WIDTH'(gi));
    assign pend_sat[gi] = !acc_hit[gi] && bus.i_deq[gi] && (pending_reg[gi] == '1);
    assign pending_next[gi] = acc_hit[gi]  ? pending_reg[gi] - cnt_reg + CNT_WIDTH'(bus.i_deq[gi]) :
                              pend_sat[gi] ? pending_reg[gi] :
                                             pending_reg[gi] + CNT_WIDTH'(bus.i_deq[gi]);
    assign flag_next[gi] = acc_hit[gi] ? 1'b0 :
                           (flag_reg[gi] | (timer_wrap && pending_reg[gi] != '0));
    assign eligible[gi]  = (pending_reg[gi] >= CNT_WIDTH'(CREDIT_BATCH)) ||
                           (flag_reg[gi] && pending_reg[gi] != '0);
  end

  assign err_next = err_reg | bad_vc | (|tx_under) | (|tx_over) | (|pend_sat);

  always_comb begin
    state_next = state_reg;
    vc_next    = vc_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    pick_found = 1'b0;
    pick_vc    = rr_reg;
    rr_sum     = '0;
    // Search starts one past the last granted VC so every VC gets a turn.
    for (int off = 1; off <= NUM_VC; off++) begin
      rr_sum = {1'b0, rr_reg} + (VC_WIDTH + 1)'(off);
      if (rr_sum >= (VC_WIDTH + 1)'(NUM_VC))
        rr_sum = rr_sum - (VC_WIDTH + 1)'(NUM_VC);
      if (!pick_found && eligible[rr_sum[VC_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_vc    = rr_sum[VC_WIDTH-1:0];
      end
    end
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_OFFER;
          vc_next    = pick_vc;
          cnt_next   = pending_reg[pick_vc];
        end
      end
      ST_OFFER: begin
        if (bus.i_us_credit_accept) begin
          state_next = ST_IDLE;
          rr_next    = vc_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        tx_credit_reg[v] <= CNT_WIDTH'(REMOTE_DEPTH);
        pending_reg[v]   <= '0;
      end
      flag_reg  <= '0;
      xoff_reg  <= '1;
      timer_reg <= '0;
      state_reg <= ST_IDLE;
      vc_reg    <= '0;
      cnt_reg   <= '0;
      rr_reg    <= VC_WIDTH'(NUM_VC - 1);
      err_reg   <= 1'b0;
    end else if (!bus.i_link_up) begin
      for (int v = 0; v < NUM_VC; v++) begin
        tx_credit_reg[v] <= CNT_WIDTH'(REMOTE_DEPTH);
        pending_reg[v]   <= '0;
      end
      flag_reg  <= '0;
      xoff_reg  <= '1;
      timer_reg <= '0;
      state_reg <= ST_IDLE;
      vc_reg    <= '0;
      cnt_reg   <= '0;
      rr_reg    <= VC_WIDTH'(NUM_VC - 1);
      err_reg   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        tx_credit_reg[v] <= tx_credit_next[v];
        pending_reg[v]   <= pending_next[v];
        xoff_reg[v]      <= (tx_credit_reg[v] < CNT_WIDTH'(XOFF_THRESH));
      end
      flag_reg  <= flag_next;
      timer_reg <= timer_wrap ? '0 : timer_reg + 1'b1;
      state_reg <= state_next;
      vc_reg    <= vc_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
      err_reg   <= err_next;
    end
  end

  assign bus.o_us_credit_valid = (state_reg == ST_OFFER);
  assign bus.o_us_credit_vc    = vc_reg;
  assign bus.o_us_credit_cnt   = cnt_reg;
  assign bus.o_xoff            = xoff_reg;
  assign bus.o_credit_err      = err_reg;
endmodule

// File: tb/tb_rio_link_vc_credits.sv
// Scoreboard bench for rio_link_vc_credits: expected credit messages are queued as
// freed slots are driven and matched on each accepted handshake; xoff/err follow a cycle model.
module tb_rio_link_vc_credits;
  localparam int NUM_VC         = 3;
  localparam int VC_WIDTH       = 2;
  localparam int CNT_WIDTH      = 8;
  localparam int REMOTE_DEPTH   = 64;
  localparam int XOFF_THRESH    = 4;
  localparam int CREDIT_BATCH   = 8;
  localparam int REFRESH_CYCLES = 256;

  typedef struct packed {
    logic [VC_WIDTH-1:0]  vc;
    logic [CNT_WIDTH-1:0] cnt;
  } msg_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rio_link_vc_credits_if #(.NUM_VC(NUM_VC), .VC_WIDTH(VC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  rio_link_vc_credits #(
    .NUM_VC(NUM_VC), .VC_WIDTH(VC_WIDTH), .CNT_WIDTH(CNT_WIDTH),
    .REMOTE_DEPTH(REMOTE_DEPTH), .XOFF_THRESH(XOFF_THRESH),
    .CREDIT_BATCH(CREDIT_BATCH), .REFRESH_CYCLES(REFRESH_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   checks   = 0;
  int   failures = 0;
  msg_t exp_q[$];

  int              cyc = 0;
  int              wrap_cyc = -1;
  int              first_valid_cyc = -1;
  bit              track_valid = 1'b0;
  int              m_credit [NUM_VC];
  logic [NUM_VC-1:0] m_xoff;
  logic            m_err;
  int              m_timer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic msg_t mk(input int vc, input int cnt);
    msg_t m;
    m.vc  = VC_WIDTH'(vc);
    m.cnt = CNT_WIDTH'(cnt);
    return m;
  endfunction

  // One clock: score any handshake at this edge, advance the model, then check outputs.
  task automatic cycle();
    msg_t e;
    int   a;
    int   n;
    if (!rst && bus.i_link_up && bus.o_us_credit_valid && bus.i_us_credit_accept) begin
      if (exp_q.size() == 0) begin
        check("msg_unexpected", 32'({bus.o_us_credit_vc, bus.o_us_credit_cnt}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("tb: cycle %0d msg vc=%0d cnt=%0d (expected vc=%0d cnt=%0d)",
                 cyc, bus.o_us_credit_vc, bus.o_us_credit_cnt, e.vc, e.cnt);
        check("msg_vc", 32'(bus.o_us_credit_vc), 32'(e.vc));
        check("msg_cnt", 32'(bus.o_us_credit_cnt), 32'(e.cnt));
      end
    end
    @(posedge clk);
    cyc++;
    if (rst || !bus.i_link_up) begin
      for (int v = 0; v < NUM_VC; v++) m_credit[v] = REMOTE_DEPTH;
      m_xoff  = '1;
      m_err   = 1'b0;
      m_timer = 0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) m_xoff[v] = (m_credit[v] < XOFF_THRESH);
      if (bus.i_ds_credit_valid && int'(bus.i_ds_credit_vc) >= NUM_VC) m_err = 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        a = (bus.i_ds_credit_valid && int'(bus.i_ds_credit_vc) == v) ? int'(bus.i_ds_credit_cnt) : 0;
        if (m_credit[v] == 0 && bus.i_enq[v] && a == 0) begin
          m_err = 1'b1;
        end else begin
          n = m_credit[v] + a - int'(bus.i_enq[v]);
          if (n > REMOTE_DEPTH) begin
            n     = REMOTE_DEPTH;
            m_err = 1'b1;
          end
          m_credit[v] = n;
        end
      end
      if (m_timer == REFRESH_CYCLES - 1) begin
        m_timer  = 0;
        wrap_cyc = cyc;
      end else begin
        m_timer++;
      end
    end
    #1;
    check("xoff", 32'(bus.o_xoff), 32'(m_xoff));
    check("credit_err", 32'(bus.o_credit_err), 32'(m_err));
    if (track_valid && bus.o_us_credit_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
  endtask

  task automatic link_bounce();
    bus.i_link_up = 1'b0;
    cycle();
    bus.i_link_up = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst                    = 1'b1;
    bus.i_link_up          = 1'b1;
    bus.i_enq              = '0;
    bus.i_ds_credit_valid  = 1'b0;
    bus.i_ds_credit_vc     = '0;
    bus.i_ds_credit_cnt    = '0;
    bus.i_deq              = '0;
    bus.i_us_credit_accept = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_valid", 32'(bus.o_us_credit_valid), 0);
    check("rst_vc", 32'(bus.o_us_credit_vc), 0);
    check("rst_cnt", 32'(bus.o_us_credit_cnt), 0);
    check("rst_xoff", 32'(bus.o_xoff), 32'h7);
    rst = 1'b0;
    repeat (2) cycle();
    check("up_xoff", 32'(bus.o_xoff), 0);
    check("up_valid", 32'(bus.o_us_credit_valid), 0);

    // TX credit drain on VC1 down to 3, then a downstream grant of 10
    bus.i_enq = 3'b010;
    repeat (61) cycle();
    bus.i_enq = '0;
    repeat (2) cycle();
    check("xoff1_low_credit", 32'(bus.o_xoff[1]), 1);
    bus.i_ds_credit_valid = 1'b1;
    bus.i_ds_credit_vc    = 2'd1;
    bus.i_ds_credit_cnt   = 8'd10;
    cycle();
    bus.i_ds_credit_valid = 1'b0;
    repeat (2) cycle();
    check("xoff1_after_grant", 32'(bus.o_xoff[1]), 0);

    // Full batch on VC0 held in OFFER, accepted together with another deq
    bus.i_deq = 3'b001;
    repeat (8) cycle();
    bus.i_deq = '0;
    check("batch_valid_not_yet", 32'(bus.o_us_credit_valid), 0);
    cycle();
    check("batch_valid_launch", 32'(bus.o_us_credit_valid), 1);
    exp_q.push_back(mk(0, 8));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.o_us_credit_valid), 1);
      check("hold_vc", 32'(bus.o_us_credit_vc), 0);
      check("hold_cnt", 32'(bus.o_us_credit_cnt), 8);
      cycle();
    end
    bus.i_us_credit_accept = 1'b1;
    bus.i_deq              = 3'b001;
    cycle();
    bus.i_deq              = '0;
    bus.i_us_credit_accept = 1'b0;
    check("accept_valid_drop", 32'(bus.o_us_credit_valid), 0);
    check("batch_scored", 32'(exp_q.size()), 0);

    // Partial counts (VC2=3, VC0=1 left over) only leave on the refresh wrap
    bus.i_deq = 3'b100;
    repeat (3) cycle();
    bus.i_deq = '0;
    exp_q.push_back(mk(2, 3));
    exp_q.push_back(mk(0, 1));
    bus.i_us_credit_accept = 1'b1;
    track_valid     = 1'b1;
    first_valid_cyc = -1;
    wrap_cyc        = -1;
    drain("refresh_drained", 400);
    track_valid = 1'b0;
    check("refresh_latency", 32'((wrap_cyc >= 0) && (first_valid_cyc - wrap_cyc >= 1) &&
                                 (first_valid_cyc - wrap_cyc <= 2)), 1);

    // Round-robin: VC0 and VC2 both full
    link_bounce();
    exp_q.push_back(mk(0, 8));
    exp_q.push_back(mk(2, 8));
    bus.i_deq = 3'b101;
    repeat (8) cycle();
    bus.i_deq = '0;
    drain("rr_round1_drained", 20);
    bus.i_us_credit_accept = 1'b0;
    exp_q.push_back(mk(0, 8));
    exp_q.push_back(mk(2, 8));
    exp_q.push_back(mk(0, 8));
    for (int i = 0; i < 16; i++) begin
      bus.i_deq = (i < 8) ? 3'b101 : 3'b001;
      cycle();
    end
    bus.i_deq = '0;
    bus.i_us_credit_accept = 1'b1;
    drain("rr_round2_drained", 30);

    // Overflow saturation, then exact xoff point from the saturated 64
    link_bounce();
    bus.i_us_credit_accept = 1'b0;
    bus.i_enq = 3'b001;
    repeat (4) cycle();
    bus.i_enq = '0;
    bus.i_ds_credit_valid = 1'b1;
    bus.i_ds_credit_vc    = 2'd0;
    bus.i_ds_credit_cnt   = 8'd10;
    cycle();
    bus.i_ds_credit_valid = 1'b0;
    check("overflow_err", 32'(bus.o_credit_err), 1);
    bus.i_enq = 3'b001;
    repeat (61) cycle();
    bus.i_enq = '0;
    repeat (2) cycle();
    check("xoff0_after_saturate", 32'(bus.o_xoff[0]), 1);

    // Link drop in the middle of an offered message
    bus.i_deq = 3'b010;
    repeat (8) cycle();
    bus.i_deq = '0;
    cycle();
    check("offer_before_drop", 32'(bus.o_us_credit_valid), 1);
    link_bounce();
    check("drop_valid", 32'(bus.o_us_credit_valid), 0);
    check("drop_err", 32'(bus.o_credit_err), 0);
    check("drop_xoff", 32'(bus.o_xoff), 32'h7);
    repeat (2) cycle();
    check("drop_no_reoffer", 32'(bus.o_us_credit_valid), 0);

    // Out-of-range downstream VC
    bus.i_ds_credit_valid = 1'b1;
    bus.i_ds_credit_vc    = 2'd3;
    bus.i_ds_credit_cnt   = 8'd5;
    cycle();
    bus.i_ds_credit_valid = 1'b0;
    check("bad_vc_err", 32'(bus.o_credit_err), 1);

    // Underflow on VC2
    link_bounce();
    bus.i_enq = 3'b100;
    repeat (64) cycle();
    check("credit_zero_no_err", 32'(bus.o_credit_err), 0);
    cycle();
    bus.i_enq = '0;
    check("underflow_err", 32'(bus.o_credit_err), 1);
    repeat (2) cycle();
    check("underflow_xoff2", 32'(bus.o_xoff[2]), 1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rio_link_vc_credits.md
Name: rio_link_vc_credits

Overview:
- Per-virtual-channel credit engine for the GTP link layer; a generalised successor to the fixed 3-VC credit block.
- Tracks transmit credits granted by the remote receiver and drives per-VC xoff to the local TX path.
- Accumulates locally freed RX buffer slots and returns them upstream as batched credit messages, using round-robin VC selection and a refresh timer for partial batches.
- Sits between rio_link_rx_ctrl (downstream credit decode), rio_link_tx_ctrl (upstream credit insertion) and the user flow-control interface.

Parameters:
- NUM_VC, 3, number of virtual channels (1..8).
- VC_WIDTH, 2, width of VC index; must satisfy 2^VC_WIDTH >= NUM_VC.
- CNT_WIDTH, 8, width of every credit counter and of the credit-message count field.
- REMOTE_DEPTH, 64, initial/maximum TX credits per VC (remote buffer words per VC); must be < 2^CNT_WIDTH.
- XOFF_THRESH, 4, o_xoff[v] asserted while tx_credit[v] < XOFF_THRESH.
- CREDIT_BATCH, 8, pending return count at which a VC becomes eligible immediately.
- REFRESH_CYCLES, 256, refresh-timer period in clk cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_link_up  in  1  link-up status; low = link re-initialisation.
- i_enq  in  NUM_VC  one word sent on VC v this cycle (consumes one TX credit).
- i_ds_credit_valid  in  1  downstream credit message received.
- i_ds_credit_vc  in  VC_WIDTH  VC of the received message.
- i_ds_credit_cnt  in  CNT_WIDTH  credits granted by the received message.
- i_deq  in  NUM_VC  one word drained from local RX buffer of VC v.
- o_us_credit_valid  out  1  upstream credit message pending.
- o_us_credit_vc  out  VC_WIDTH  VC of the pending message.
- o_us_credit_cnt  out  CNT_WIDTH  count carried by the pending message.
- i_us_credit_accept  in  1  TX path consumed the message this cycle.
- o_xoff  out  NUM_VC  per-VC transmit stop, registered.
- o_credit_err  out  1  sticky credit protocol error.

Behaviour:
- Reset values: tx_credit[v]=REMOTE_DEPTH; pending[v]=0; refresh flags 0; timer 0; o_xoff all ones; o_us_credit_valid=0; o_us_credit_vc=0; o_us_credit_cnt=0; o_credit_err=0.
- Link down (i_link_up=0), applied synchronously:
  - Same state as reset, except o_credit_err is cleared.
  - i_enq, i_deq and i_ds_credit_valid are ignored.
  - o_us_credit_valid drops immediately in the next cycle, even mid-handshake.
- TX credits per VC, with e=i_enq[v] and a=i_ds_credit_cnt when i_ds_credit_valid and i_ds_credit_vc==v, else 0:
  - next = tx_credit + a - e, computed at CNT_WIDTH+1 bits.
  - If next > REMOTE_DEPTH: saturate to REMOTE_DEPTH and set o_credit_err (overflow).
  - If tx_credit==0 and e=1 and a=0: counter stays 0 and o_credit_err is set (underflow).
  - An i_ds_credit_vc >= NUM_VC sets o_credit_err; the message is dropped.
- o_xoff[v] is registered: it reflects tx_credit[v] < XOFF_THRESH one cycle after the counter update. It is forced to 1 while the link is down.
- Pending return per VC:
  - pending[v] += i_deq[v], saturating at 2^CNT_WIDTH-1; saturation sets o_credit_err.
  - On accept of a message for VC v: pending[v] = pending[v] - o_us_credit_cnt + i_deq[v], evaluated in the same cycle.
- Refresh timer:
  - Free-running counter 0..REFRESH_CYCLES-1.
  - On wrap, sets refresh flag[v] for every VC with pending[v] > 0.
  - flag[v] is cleared when a message for VC v is accepted.
- Eligibility: VC v is eligible when pending[v] >= CREDIT_BATCH, or when flag[v]=1 and pending[v] > 0.
- Message state machine:
  - IDLE: if any VC is eligible, pick by round-robin starting after the last granted VC. Register vc and cnt=pending[vc] snapshot, assert o_us_credit_valid next cycle, go to OFFER.
  - OFFER: vc and cnt stay stable while valid=1 and accept=0.
  - On accept: deassert valid, advance RR pointer, return to IDLE. Minimum spacing is one idle cycle between messages.
- Latency:
  - i_deq to earliest o_us_credit_valid: 2 cycles (counter update, then launch).
  - i_enq / downstream credit to o_xoff: 2 cycles.

Test Plan:
- Reset, link up, NUM_VC=3 -> o_xoff=000 after 2 cycles; tx_credit=64; no message offered.
- 61 i_enq on VC1 -> o_xoff[1]=1 exactly when credits reach 3; then a downstream credit {vc=1,cnt=10} -> credits 13 and o_xoff[1]=0.
- 8 i_deq on VC0, accept held low for 5 cycles -> o_us_credit {vc=0,cnt=8} held stable; accept -> pending 0; a deq in the accept cycle leaves pending 1.
- 3 i_deq on VC2 only -> no message until timer wrap; message {vc=2,cnt=3} within 2 cycles of wrap.
- VC0 and VC2 both at 8 pending with accept always 1 -> messages alternate VC0, VC2 by round-robin; VC1 never granted.
- Downstream credit of 10 with credits at 60 -> credits saturate at 64 and o_credit_err=1; i_link_up low one cycle -> o_credit_err=0, o_xoff=111, valid=0.
